// File: rtl/conv_window_ctrl_if.sv
// Pixel stream in, 3x3 window out and result-valid return between the window
// sequencer and the convolution datapath.
interface conv_window_ctrl_if;
  logic [7:0]  pix_in;
  logic        pix_valid_in;
  logic        pix_ready_out;
  logic [71:0] window_data_out;
  logic        window_valid_out;
  logic        conv_valid_in;

  modport slave (
    input  pix_in, pix_valid_in, conv_valid_in,
    output pix_ready_out, window_data_out, window_valid_out
  );

  modport master (
    output pix_in, pix_valid_in, conv_valid_in,
    input  pix_ready_out, window_data_out, window_valid_out
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 3x3 convolution: two line buffers, window register,
// result counting. Define CONV_CTRL_ERR_CHECK_EN to add the sticky err_out port.
module conv_window_ctrl #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  conv_window_ctrl_if.slave bus,
  output logic              busy_out,
  output logic              done_out
`ifdef CONV_CTRL_ERR_CHECK_EN
  ,
  output logic              err_out
`endif
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int NUM_WIN = (IMG_W - 2) * (IMG_H - 2);
  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int CNT_W   = $clog2(NUM_PIX + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0] RES_FULL = CNT_W'(NUM_WIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_nxt;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] res_q, res_nxt;
  logic [71:0]      win_q, win_nxt;
  logic [71:0]      win_out_q;
  logic             win_valid_q;

  logic [7:0] lb0_mem [IMG_W];
  logic [7:0] lb1_mem [IMG_W];

  logic start_ok;
  logic accept;
  logic emit;
  logic res_live;
  logic res_inc;

  assign start_ok = (state_q == S_IDLE) && start_in;
  assign bus.pix_ready_out = (state_q == S_FILL) || (state_q == S_RUN);
  assign accept   = bus.pix_valid_in && bus.pix_ready_out;
  // Left two window columns share the accepted pixel's line only from col 2 on.
  assign emit     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign res_live = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign res_inc  = bus.conv_valid_in && res_live && (res_q != RES_FULL);
  assign res_nxt  = res_q + CNT_W'(res_inc);

  assign busy_out             = res_live;
  assign done_out             = (state_q == S_DONE);
  assign bus.window_data_out  = win_out_q;
  assign bus.window_valid_out = win_valid_q;

  // Window shifted one column left with the new right column appended.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[(3*r)*8   +: 8] = win_q[(3*r+1)*8 +: 8];
      win_nxt[(3*r+1)*8 +: 8] = win_q[(3*r+2)*8 +: 8];
    end
    win_nxt[2*8 +: 8] = lb1_mem[col_q];
    win_nxt[5*8 +: 8] = lb0_mem[col_q];
    win_nxt[8*8 +: 8] = bus.pix_in;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_nxt = S_FILL;
      S_FILL:  if (accept && (row_q == ROW_W'(1)) && (col_q == COL_LAST)) state_nxt = S_RUN;
      S_RUN:   if (accept && (acc_q == ACC_LAST)) state_nxt = S_DRAIN;
      S_DRAIN: if (res_nxt == RES_FULL) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: reset is synchronous: it is only seen on a rising clock edge.
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      win_q       <= '0;
      win_out_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      win_valid_q <= emit;
      if (start_ok) begin
        col_q <= '0;
        row_q <= '0;
        acc_q <= '0;
        res_q <= '0;
      end else begin
        res_q <= res_nxt;
        if (accept) begin
          acc_q <= acc_q + CNT_W'(1);
          win_q <= win_nxt;
          if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
          if (emit) win_out_q <= win_nxt;
        end
      end
    end
  end

  // NOTE: line-buffer RAM has no reset; rows 0/1 overwrite it before any window uses it.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      lb1_mem[col_q] <= lb0_mem[col_q];
      lb0_mem[col_q] <= bus.pix_in;
    end
  end

`ifdef CONV_CTRL_ERR_CHECK_EN
  logic err_q;
  logic err_evt;

  assign err_evt = (bus.conv_valid_in &&
                    ((state_q == S_IDLE) || (state_q == S_DONE) || (res_q == RES_FULL))) ||
                   (bus.pix_valid_in && (state_q == S_DRAIN));
  assign err_out = err_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)    err_q <= 1'b0;
    else if (err_evt) err_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl on a 5x4 frame with a 3-cycle conv model.
module tb_conv_window_ctrl;
  localparam int IMG_W   = 5;
  localparam int IMG_H   = 4;
  localparam int NUM_WIN = (IMG_W - 2) * (IMG_H - 2);
  localparam logic [71:0] FIRST_WIN = 72'h16_15_14_0C_0B_0A_02_01_00;

  typedef struct {
    logic [71:0] data;
    int          cyc;
  } exp_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic start_in = 1'b0;
  logic busy_out;
  logic done_out;
`ifdef CONV_CTRL_ERR_CHECK_EN
  logic err_out;
`endif

  conv_window_ctrl_if bus ();

  conv_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start_in (start_in),
    .bus      (bus),
    .busy_out (busy_out),
    .done_out (done_out)
`ifdef CONV_CTRL_ERR_CHECK_EN
    ,
    .err_out  (err_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   frame_win    = 0;
  int   n_done       = 0;
  int   total_done   = 0;
  int   last_win_cyc = 0;
  logic [71:0] last_win = '0;
  logic [2:0]  conv_pipe   = '0;
  logic        conv_inject = 1'b0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [71:0] win_of(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int k = 0; k < 3; k++)
        w[(3*rr+k)*8 +: 8] = 8'(10 * (r - 2 + rr) + (c - 2 + k));
    return w;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // Conv model (result returns three cycles after the accept) plus output monitor.
  always @(posedge clk_in) begin
    #1;
    conv_pipe = rst_n_in ? {conv_pipe[1:0], bus.window_valid_out} : 3'b000;
    bus.conv_valid_in = conv_pipe[2] | conv_inject;
    if (bus.window_valid_out) begin
      check("win_expected", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("win_data", bus.window_data_out, mon_e.data);
        check("win_cycle", 72'(cyc), 72'(mon_e.cyc));
      end
      if (frame_win == 0) check("first_win", bus.window_data_out, FIRST_WIN);
      frame_win++;
      last_win     = bus.window_data_out;
      last_win_cyc = cyc;
    end
    if (done_out) begin
      check("done_latency", 72'(cyc - last_win_cyc), 72'd3);
      check("busy_in_done", 72'(busy_out), 72'd0);
      n_done++;
      total_done++;
    end
  end

  task automatic drive_pixels(input int n_pix, input bit gap, input bit start_mid);
    for (int idx = 0; idx < n_pix; idx++) begin
      int r;
      int c;
      int guard;
      r = idx / IMG_W;
      c = idx % IMG_W;
      guard = 0;
      if (gap) begin
        @(negedge clk_in);
        bus.pix_valid_in = 1'b0;
        start_in = 1'b0;
      end
      @(negedge clk_in);
      bus.pix_in       = 8'(10 * r + c);
      bus.pix_valid_in = 1'b1;
      start_in         = start_mid && (idx == 12);
      while (!bus.pix_ready_out && guard < 20) begin
        @(negedge clk_in);
        guard++;
      end
      if (!bus.pix_ready_out) begin
        check("ready_timeout", 72'(bus.pix_ready_out), 72'd1);
        bus.pix_valid_in = 1'b0;
        return;
      end
      if (r >= 2 && c >= 2) exp_q.push_back('{data: win_of(r, c), cyc: cyc + 1});
    end
    @(negedge clk_in);
    bus.pix_valid_in = 1'b0;
    start_in = 1'b0;
  endtask

  task automatic run_frame(input bit gap, input bit start_mid);
    int guard;
    guard     = 0;
    frame_win = 0;
    n_done    = 0;
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check("busy_after_start", 72'(busy_out), 72'd1);
    drive_pixels(IMG_W * IMG_H, gap, start_mid);
    while (n_done == 0 && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    check("done_seen", 72'(n_done), 72'd1);
    check("win_count", 72'(frame_win), 72'(NUM_WIN));
    check("last_win_byte8", 72'(last_win[71:64]), 72'd34);
    check("sb_empty", 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_in        = '0;
    bus.pix_valid_in  = 1'b0;
    bus.conv_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_busy", 72'(busy_out), 72'd0);
    check("rst_done", 72'(done_out), 72'd0);
    check("rst_ready", 72'(bus.pix_ready_out), 72'd0);
    check("rst_wvalid", 72'(bus.window_valid_out), 72'd0);
    check("rst_wdata", bus.window_data_out, 72'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("idle_busy", 72'(busy_out), 72'd0);

    run_frame(1'b0, 1'b0);   // continuous stream
    run_frame(1'b1, 1'b0);   // valid toggling every other cycle
    run_frame(1'b0, 1'b1);   // stray start during RUN

    // Abort a frame after 12 accepted pixels.
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    n_done = 0;
    drive_pixels(12, 1'b0, 1'b0);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    check("abort_busy", 72'(busy_out), 72'd0);
    check("abort_ready", 72'(bus.pix_ready_out), 72'd0);
    check("abort_wdata", bus.window_data_out, 72'd0);
    exp_q.delete();
    repeat (10) @(negedge clk_in);
    check("abort_no_done", 72'(n_done), 72'd0);

    run_frame(1'b0, 1'b0);   // fresh frame after reset
    run_frame(1'b0, 1'b0);   // back-to-back with the previous frame
    check("total_done", 72'(total_done), 72'd5);

`ifdef CONV_CTRL_ERR_CHECK_EN
    check("err_clean", 72'(err_out), 72'd0);
    @(negedge clk_in);
    conv_inject = 1'b1;
    @(negedge clk_in);
    conv_inject = 1'b0;
    check("err_not_yet", 72'(err_out), 72'd0);
    @(negedge clk_in);
    check("err_set", 72'(err_out), 72'd1);
    repeat (5) @(negedge clk_in);
    check("err_sticky", 72'(err_out), 72'd1);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    check("err_cleared", 72'(err_out), 72'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Frame-level sequencer for the 3x3 convolution datapath.
- Accepts a raster-order 8-bit pixel stream and holds two line buffers plus a 3x3 window register.
- Issues one 72-bit window with a valid strobe per interior pixel to the convolution block.
- Counts the filtered results that come back and signals end of frame.

Parameters:
- IMG_W, 320, pixels per line; must be >= 3.
- IMG_H, 240, lines per frame; must be >= 3.

Ports:
- clk_in  in  1  clock; all logic is on the rising edge.
- rst_n_in  in  1  synchronous reset, active-low.
- start_in  in  1  one-cycle frame start request.
- pix_in  in  8  input pixel.
- pix_valid_in  in  1  pix_in is valid.
- pix_ready_out  out  1  controller accepts pix_in this cycle.
- window_data_out  out  72  3x3 window to the convolution block.
- window_valid_out  out  1  window_data_out is valid.
- conv_valid_in  in  1  result-valid strobe returned by the convolution block.
- busy_out  out  1  frame in progress.
- done_out  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset, sampled on clk_in while rst_n_in=0:
  - state goes to IDLE.
  - col, row, accept and result counters clear to 0.
  - All outputs are 0, including window_data_out.
  - Line-buffer RAM is not cleared.
- A reset mid-frame aborts the frame. No done_out is issued.
- States:
  - IDLE: start_in=1 -> FILL. busy_out=1 from the next cycle.
  - FILL: accept pixels. When the accepted pixel is at row=1, col=IMG_W-1 -> RUN.
  - RUN: accept pixels. When the accepted pixel is at row=IMG_H-1, col=IMG_W-1 -> DRAIN.
  - DRAIN: no input accepted. When result count reaches (IMG_W-2)*(IMG_H-2) -> DONE.
  - DONE: done_out=1 and busy_out=0 for exactly one cycle, then IDLE.
- Handshake:
  - pix_ready_out = 1 only in FILL or RUN.
  - A pixel is accepted on a cycle where pix_valid_in and pix_ready_out are both 1.
  - Gaps in pix_valid_in hold all counters and the window; no window is emitted during a gap.
- Pixel accept at column c (current col counter):
  - Window shifts one column left.
  - New right column is filled as: top = lb1[c], middle = lb0[c], bottom = pix_in.
  - Line buffers update as lb1[c] <= lb0[c] and lb0[c] <= pix_in.
  - col increments and wraps IMG_W-1 -> 0; row increments on wrap.
- Window emission:
  - Only when the accepted pixel has row>=2 and col>=2.
  - window_valid_out=1 in the cycle after the accept, with the updated window on window_data_out. Latency is 1 cycle.
  - Byte layout: window_data_out[(3*r+k)*8 +: 8], where r=0 is the top (oldest) row and k=0 is the leftmost column.
  - The accepted pixel is byte 8.
- Border handling:
  - No windows for row 0, row 1, col 0 or col 1.
  - Windows never span a line wrap: col>=2 guarantees the left two columns come from the same line.
  - Windows per frame = (IMG_W-2)*(IMG_H-2).
- Result counting:
  - conv_valid_in increments the result counter in FILL, RUN and DRAIN.
  - conv_valid_in is ignored in IDLE and DONE.
  - The convolution block's 3-cycle latency means DRAIN lasts at least 3 cycles.
- start_in is ignored outside IDLE.
- window_data_out holds its last value when window_valid_out=0.
- Counter widths are $clog2-sized from IMG_W, IMG_H and IMG_W*IMG_H, with no overflow at the maximum count.

Optional Feature:
- Macro: CONV_CTRL_ERR_CHECK_EN.
- With the macro defined:
  - Adds output port err_out, width 1, sticky; cleared only by reset.
  - err_out sets when conv_valid_in=1 in IDLE or DONE.
  - err_out sets when conv_valid_in=1 and the result count already equals (IMG_W-2)*(IMG_H-2).
  - err_out sets when pix_valid_in=1 in DRAIN.
  - err_out asserts in the cycle after the offending event.
  - Normal sequencing is otherwise unchanged.
- Without the macro: err_out and its logic are absent; behaviour is otherwise identical.

Test Plan:
- IMG_W=5, IMG_H=4, pixel value = 10*row+col, pix_valid_in held at 1, conv model with 3-cycle latency:
  - Exactly 6 windows.
  - First window bytes 0..8 = 0,1,2,10,11,12,20,21,22, one cycle after pixel 22 is accepted.
  - Last window ends with byte 8 = 34.
  - done_out pulses once, 3 cycles after the last window.
- Same frame with pix_valid_in toggling every other cycle: identical window sequence, with no window_valid_out on idle cycles.
- start_in pulsed during RUN: no effect; frame still produces 6 windows and 1 done_out.
- rst_n_in=0 for one cycle after 12 accepted pixels, then a fresh start and a full frame:
  - busy_out=0 right after reset.
  - The new frame's first window = 0,1,2,10,11,12,20,21,22.
- Back-to-back frames with start_in in the cycle after done_out: second frame output is identical to the first.
- CONV_CTRL_ERR_CHECK_EN defined, extra conv_valid_in pulse in IDLE: err_out=1 next cycle and stays 1 until reset.
